stopwatch_counter: RTL
======================

# stopwatch_counter

Centisecond stopwatch datapath sitting directly downstream of the pause/resume toggle FSM: it consumes that FSM's `state` bit as a count enable and advances a BCD time value (SS.CC) once per 100 Hz tick while running. It also provides a clear function and a lap-hold function that freezes the displayed value while counting continues. Its outputs drive the seven-segment display scanner.

## Interface
Parameters:
- `SEC_LIMIT`, default 60: seconds modulus. Legal range 10..100. Seconds count 0..SEC_LIMIT-1.

Ports:
- `clk_100hz`  input  1  sole clock, 100 Hz.
- `rst`  input  1  reset, synchronous, active-high.
- `count_en`  input  1  1 = resume (count), 0 = pause; driven by the pause/resume FSM `state`.
- `clear`  input  1  one-cycle pulse; zeroes the time and cancels lap hold.
- `lap`  input  1  one-cycle pulse; toggles lap hold.
- `sec_tens`  output  4  displayed seconds tens digit, BCD.
- `sec_ones`  output  4  displayed seconds units digit, BCD.
- `cs_tens`  output  4  displayed centiseconds tens digit, BCD.
- `cs_ones`  output  4  displayed centiseconds units digit, BCD.
- `lap_active`  output  1  1 while the display is frozen.
- `wrap`  output  1  one-cycle pulse after rollover from max to 00.00.

## Operation
- Running register R: four BCD digits. Snapshot register S: four BCD digits. Lap flag L.
- Increment when `count_en`=1: cs_ones 9->0 carries to cs_tens; cs_tens 9->0 carries to sec_ones; sec_ones 9->0 carries to sec_tens. When seconds = SEC_LIMIT-1 and cs = 99, R goes to 00.00.
- Increment when `count_en`=0: R holds.
- Digits never leave 0..9. Seconds never reach SEC_LIMIT.
- Display: L=0 -> outputs show R. L=1 -> outputs show S.
- `lap` with L=0: S <= R (the pre-edge value), L <= 1.
- `lap` with L=1: L <= 0. S is don't-care.
- `clear`: R <= 00.00, S <= 00.00, L <= 0. This happens regardless of `count_en` or `lap`.
- Priority at the same edge: `rst` > `clear` > increment/lap.
- `lap` and increment at the same edge: both take effect. S captures the pre-increment R.
- `wrap` <= 1 for exactly the cycle following a rollover edge, otherwise 0. `clear` does not assert `wrap`.
- Lap state is independent of `count_en`. Pausing while L=1 keeps the display frozen.

## Timing
- `rst` sampled high at a clock edge: R = S = 00.00, L = 0, `wrap` = 0.
  - All outputs read 0 in the cycle after that edge.
  - Reset asserted mid-count or mid-lap behaves identically.
- Latency: `count_en` sampled 1 at edge k -> displayed value (when L=0) reflects +1 cs after edge k. One cycle, no extra pipeline.
- `clear`/`lap` take effect at the edge where they are sampled high. Outputs reflect them in the following cycle.
- Outputs depend only on registers. There is no combinational path from any input to any output.
- Pulse inputs held high for multiple cycles act once per cycle. `lap` held high toggles L every cycle; upstream one-pulse logic prevents this.

## Test plan
- Reset then `count_en`=1 for 150 cycles -> outputs 01.50, `lap_active`=0, `wrap` never asserted.
- Preload to 59.98 by counting 5998 cycles, then 2 more enabled cycles:
  - Outputs go 59.99 then 00.00.
  - `wrap`=1 for exactly one cycle, aligned with 00.00.
  - Repeat with SEC_LIMIT=100: rollover occurs at 99.99 -> 00.00.
- Count to 03.25 with `lap` pulsed at that edge, continue 100 cycles:
  - Display holds 03.25 with `lap_active`=1.
  - Second `lap` pulse -> display shows live value 04.26 next cycle, `lap_active`=0.
- Count to 00.40, drop `count_en` for 50 cycles -> outputs stay 00.40. Re-enable 10 cycles -> 00.50.
- With `count_en`=1 and L=1, pulse `clear` together with `lap` -> next cycle outputs 00.00, `lap_active`=0. One cycle later the display reads 00.01.
- Assert `rst` for 1 cycle at 12.34 with L=1 and `count_en`=1 -> next cycle all outputs 0, `lap_active`=0, `wrap`=0. Counting resumes from 00.00.

Source files
------------

// File: rtl/stopwatch_counter.sv
// Centisecond stopwatch datapath: BCD SS.CC running count with clear,
// lap-hold snapshot display and a one-cycle rollover pulse.
module stopwatch_counter #(
   parameter int SEC_LIMIT = 60
) (
   input  logic       clk_100hz,
   input  logic       rst,
   input  logic       count_en,
   input  logic       clear,
   input  logic       lap,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic [3:0] cs_tens,
   output logic [3:0] cs_ones,
   output logic       lap_active,
   output logic       wrap
);

   localparam logic [3:0] MAX_SEC_TENS = 4'((SEC_LIMIT - 1) / 10);
   localparam logic [3:0] MAX_SEC_ONES = 4'((SEC_LIMIT - 1) % 10);

   logic [3:0] run_st, run_so, run_ct, run_co;
   logic [3:0] snap_st, snap_so, snap_ct, snap_co;
   logic [3:0] nxt_st, nxt_so, nxt_ct, nxt_co;
   logic       lap_hold;
   logic       at_max;

   assign at_max = (run_st == MAX_SEC_TENS) && (run_so == MAX_SEC_ONES) &&
                   (run_ct == 4'd9) && (run_co == 4'd9);

   // BCD ripple carry from centisecond units up to seconds tens
   always_comb begin
      nxt_st = run_st;
      nxt_so = run_so;
      nxt_ct = run_ct;
      nxt_co = run_co;
      if (at_max) begin
         nxt_st = 4'd0;
         nxt_so = 4'd0;
         nxt_ct = 4'd0;
         nxt_co = 4'd0;
      end else if (run_co != 4'd9) begin
         nxt_co = run_co + 4'd1;
      end else begin
         nxt_co = 4'd0;
         if (run_ct != 4'd9) begin
            nxt_ct = run_ct + 4'd1;
         end else begin
            nxt_ct = 4'd0;
            if (run_so != 4'd9) begin
               nxt_so = run_so + 4'd1;
            end else begin
               nxt_so = 4'd0;
               nxt_st = run_st + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk_100hz) begin
      if (rst || clear) begin
         run_st   <= 4'd0;
         run_so   <= 4'd0;
         run_ct   <= 4'd0;
         run_co   <= 4'd0;
         snap_st  <= 4'd0;
         snap_so  <= 4'd0;
         snap_ct  <= 4'd0;
         snap_co  <= 4'd0;
         lap_hold <= 1'b0;
         wrap     <= 1'b0;
      end else begin
         wrap <= count_en && at_max;
         if (count_en) begin
            run_st <= nxt_st;
            run_so <= nxt_so;
            run_ct <= nxt_ct;
            run_co <= nxt_co;
         end
         // Snapshot takes the pre-increment value when lap and count coincide
         if (lap) begin
            if (!lap_hold) begin
               snap_st <= run_st;
               snap_so <= run_so;
               snap_ct <= run_ct;
               snap_co <= run_co;
            end
            lap_hold <= !lap_hold;
         end
      end
   end

   assign sec_tens   = lap_hold ? snap_st : run_st;
   assign sec_ones   = lap_hold ? snap_so : run_so;
   assign cs_tens    = lap_hold ? snap_ct : run_ct;
   assign cs_ones    = lap_hold ? snap_co : run_co;
   assign lap_active = lap_hold;

endmodule
